// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver; 2-flop synchroniser, oversampled start/data/stop sampling, one-byte valid/ack holding register.
// Latency: rx_valid rises 9.5 bit times plus 3..SAMPLE_DIV+4 cycles after the start-bit falling edge.
// Backpressure: single holding register; a byte completing while one is held and not acked is dropped and rx_overrun pulses.
module uart_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int SAMPLE_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TICK_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int OS_W       = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [OS_W-1:0]   OS_FULL  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]   OS_ONE   = OS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic [TICK_W-1:0] r_tick_cnt;
  state_t            r_state;
  logic [OS_W-1:0]   r_os_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_deliver;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_valid;
  logic [7:0]        r_data;

  logic              w_rxd;
  logic              w_tick;
  state_t            w_state_nxt;
  logic [OS_W-1:0]   w_os_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_deliver;
  logic              w_frame_err;

  assign w_rxd  = r_sync2;
  assign w_tick = (r_tick_cnt == '0);

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample tick divider: tick when zero, then reload.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= TICK_MAX;
    end else begin
      r_tick_cnt <= r_tick_cnt - TICK_W'(1);
    end
  end

  // Receive FSM next state: every decision is taken only on a sample tick.
  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxd) begin
            w_state_nxt = S_START;
            w_os_nxt    = OS_HALF;
          end
        end
        S_START: begin
          if (r_os_cnt != '0) begin
            w_os_nxt = r_os_cnt - OS_ONE;
          end else if (!w_rxd) begin
            w_state_nxt = S_DATA;
            w_os_nxt    = OS_FULL;
            w_bit_nxt   = 3'd0;
          end else begin
            // Line went high again before mid start bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end
        end
        S_DATA: begin
          if (r_os_cnt != '0) begin
            w_os_nxt = r_os_cnt - OS_ONE;
          end else begin
            w_shift_nxt = {w_rxd, r_shift[7:1]};
            w_os_nxt    = OS_FULL;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (r_os_cnt != '0) begin
            w_os_nxt = r_os_cnt - OS_ONE;
          end else if (w_rxd) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
        S_BREAK: begin
          // Hold here until the line idles so a stuck-low line cannot retrigger.
          if (w_rxd) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, counters, shift register and registered stop-bit decisions.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state     <= S_IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_os_cnt    <= w_os_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_deliver   <= w_deliver;
      r_frame_err <= w_frame_err;
    end
  end

  // Holding register: load on delivery if empty or being acked, else flag overrun.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || rx_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid     = r_valid;
  assign rx_data      = r_data;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
